// File: rtl/clock_phase_pkg.sv
// Shared configuration type and constants for the multi-channel clock/strobe generator.
package clock_phase_pkg;

   // Fields are sized for the widest supported build; narrower builds use the low bits.
   localparam int unsigned CNT_W_MAX = 16;

   typedef struct packed {
      logic [CNT_W_MAX-1:0] half;
      logic [CNT_W_MAX:0]   phase;
      logic                 inv;
   } cfg_t;

   localparam cfg_t RST_CFG = '{half: 16'd2, phase: 17'd0, inv: 1'b0};

   localparam int unsigned CH_IMEM = 0;
   localparam int unsigned CH_DMEM = 1;
   localparam int unsigned CH_PROC = 2;
   localparam int unsigned CH_RF   = 3;

   function automatic cfg_t rst_cfg(input int unsigned half);
      cfg_t c;
      c.half  = CNT_W_MAX'(half);
      c.phase = '0;
      c.inv   = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/clock_phase_gen_if.sv
// Configuration bus of clock_phase_gen: per-channel staging writes, commit request and busy.
interface clock_phase_gen_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 6
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic            cfg_wr;
   logic [CH_W-1:0] cfg_ch;
   logic [CNT_W-1:0] cfg_half;
   logic [CNT_W:0]  cfg_phase;
   logic            cfg_inv;
   logic            apply;
   logic            busy;

   modport master (
      output cfg_wr, cfg_ch, cfg_half, cfg_phase, cfg_inv, apply,
      input  busy
   );

   modport slave (
      input  cfg_wr, cfg_ch, cfg_half, cfg_phase, cfg_inv, apply,
      output busy
   );

endinterface

// File: rtl/phase_channel.sv
// One divided-clock channel: wrapping counter, registered clock output and end-of-period strobe.
module phase_channel
   import clock_phase_pkg::*;
#(
   parameter int unsigned CNT_W = 6
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load,
   input  logic [CNT_W:0] load_val,
   input  cfg_t           cfg,
   output logic           clk_out,
   output logic           edge_stb
);

   localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

   logic [CNT_W:0] half;
   logic [CNT_W:0] last;
   logic [CNT_W:0] cnt_q;
   logic [CNT_W:0] cnt_d;

   // cfg is the next-active config, so a load already sees the newly committed half/inv.
   assign half = {1'b0, cfg.half[CNT_W-1:0]};
   assign last = {cfg.half[CNT_W-1:0], 1'b0} - ONE;

   always_comb begin
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q >= last) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         clk_out  <= 1'b0;
         edge_stb <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         clk_out  <= (cnt_d >= half) ^ cfg.inv;
         edge_stb <= (cnt_d == last);
      end
   end

   logic unused_cfg;
   assign unused_cfg = ^{cfg.phase, cfg.half[CNT_W_MAX-1:CNT_W]};

endmodule

// File: rtl/clock_phase_gen.sv
// Multi-channel clock/strobe generator with staged configs committed together
// on a channel-0 period boundary.
module clock_phase_gen
   import clock_phase_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned RST_HALF = 2
) (
   input  logic              clock,
   input  logic              reset,
   clock_phase_gen_if.slave  cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] edge_stb
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PENDING = 1'b1;

   localparam cfg_t CFG_RST = rst_cfg(RST_HALF);

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic             commit;
   logic [CNT_W-1:0] wr_half;
   cfg_t             wr_cfg;

   assign wr_half = (cfg.cfg_half == '0) ? CNT_W'(1) : cfg.cfg_half;

   always_comb begin
      wr_cfg       = '0;
      wr_cfg.half  = CNT_W_MAX'(wr_half);
      wr_cfg.phase = (CNT_W_MAX+1)'(cfg.cfg_phase);
      wr_cfg.inv   = cfg.cfg_inv;
   end

   // Channel 0 strobe is registered from cnt == 2H-1, i.e. it marks its last period cycle.
   assign commit = (state_q == PENDING) && edge_stb[CH_IMEM];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cfg.apply) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (commit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign cfg.busy = (state_q == PENDING);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      cfg_t           stg_q;
      cfg_t           stg_d;
      cfg_t           act_q;
      cfg_t           act_d;
      logic [CNT_W:0] period_s;
      logic [CNT_W:0] load_val;

      // Commit reads stg_q, so a write landing in the commit cycle waits for the next apply.
      always_comb begin
         stg_d = stg_q;
         if (cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i))) begin
            stg_d = wr_cfg;
         end
         act_d = commit ? stg_q : act_q;
      end

      assign period_s = {stg_q.half[CNT_W-1:0], 1'b0};
      assign load_val = stg_q.phase[CNT_W:0] % period_s;

      always_ff @(posedge clock) begin
         if (reset) begin
            stg_q <= CFG_RST;
            act_q <= CFG_RST;
         end else begin
            stg_q <= stg_d;
            act_q <= act_d;
         end
      end

      phase_channel #(
         .CNT_W (CNT_W)
      ) u_channel (
         .clock    (clock),
         .reset    (reset),
         .load     (commit),
         .load_val (load_val),
         .cfg      (act_d),
         .clk_out  (clk_out[i]),
         .edge_stb (edge_stb[i])
      );

      logic unused_stg;
      assign unused_stg = ^{stg_q.half[CNT_W_MAX-1:CNT_W], stg_q.phase[CNT_W_MAX:CNT_W+1]};
   end

endmodule
